fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL take parameter DEPTH, default 4, setting prefetch queue entries and the maximum number of in-flight requests (power of two, 2..16).
REQ-002 The block SHALL take parameter XLEN, default 64, setting the PC width.
REQ-003 CLK  in  1  single clock; all state updates on posedge.
REQ-004 resetl  in  1  asynchronous, active-low reset.
REQ-005 startpc  in  XLEN  fetch address loaded while resetl is low.
REQ-006 redirect  in  1  branch/jump taken; flush and refetch.
REQ-007 redirect_pc  in  XLEN  new fetch address, valid with redirect.
REQ-008 imem_req_valid  out  1  fetch request valid.
REQ-009 imem_req_addr  out  XLEN  fetch address.
REQ-010 imem_req_ready  in  1  memory accepts request this cycle.
REQ-011 imem_resp_valid  in  1  instruction word returned; in order, at least 1 cycle after acceptance.
REQ-012 imem_resp_data  in  32  instruction word.
REQ-013 inst_valid  out  1  instruction available to decode.
REQ-014 inst_data  out  32  head instruction.
REQ-015 inst_pc  out  XLEN  PC of the head instruction.
REQ-016 inst_ready  in  1  decode consumes head this cycle.

Function
REQ-017 A request SHALL be accepted when imem_req_valid && imem_req_ready; fetch_pc then advances by 4, wrapping modulo 2^XLEN.
REQ-018 imem_req_valid SHALL be high only when occupancy + outstanding < DEPTH, redirect is low, and resetl is high; this credit rule guarantees the queue never overflows.
REQ-019 imem_req_valid and imem_req_addr SHALL hold stable until acceptance, except when withdrawn by redirect.
REQ-020 A non-discarded response SHALL push {fetch PC of that request, imem_resp_data} into the queue; entries SHALL appear on inst_valid the cycle after the response (no bypass).
REQ-021 A pop occurs on inst_valid && inst_ready; push and pop SHALL be allowed in the same cycle at any occupancy, including a full queue.
REQ-022 On redirect the block SHALL empty the queue, SHALL set fetch_pc to redirect_pc with bits [1:0] forced to zero, and SHALL issue the first new request no earlier than the following cycle.
REQ-023 Every response due to a request accepted before the redirect cycle SHALL be discarded, including one arriving in the redirect cycle; a discard counter SHALL be loaded with outstanding minus any response arriving that cycle.
REQ-024 In the redirect cycle inst_valid MAY still be high and a pop that cycle SHALL be honoured; the queue is empty from the next cycle.
REQ-025 Back-to-back redirects SHALL each restart fetch, and the discard counter SHALL accumulate correctly.
REQ-026 outstanding and discard counters SHALL be clog2(DEPTH)+1 bits and SHALL never underflow or overflow under legal memory behaviour.

Reset
REQ-027 While resetl is low: fetch_pc = startpc, queue empty, outstanding = 0, discard = 0, imem_req_valid = 0, inst_valid = 0, inst_data = 0, inst_pc = 0.
REQ-028 Reset mid-operation SHALL abandon all in-flight state; the instruction memory SHALL share resetl so that no pre-reset response arrives afterwards.
REQ-029 The first request SHALL assert in the first cycle after resetl deasserts, with address startpc.

Structure
REQ-030 A shared package fetch_pkg SHALL hold XLEN default, INST_W = 32, PC_STEP = 4, and the queue entry type {pc, inst}.
REQ-031 The queue SHALL be a sub-module fetch_fifo (synchronous push/pop, flush input, registered outputs); fetch_queue holds the PC, credit and discard logic.

Verification
REQ-032 Scenario: startpc = 0x1000, inst_ready = 1, zero-wait memory -> inst_pc sequence 0x1000, 0x1004, 0x1008 with one instruction per cycle in steady state.
REQ-033 Scenario: inst_ready = 0, DEPTH = 4 -> exactly 4 requests accepted, then imem_req_valid = 0; after one pop, exactly one further request is issued.
REQ-034 Scenario: 3 requests outstanding, redirect to 0x2002 -> 3 responses dropped; next inst_pc = 0x2000.
REQ-035 Scenario: redirect in the same cycle as a response and a pop -> pop honoured, response dropped, no stale inst_pc appears afterwards.
REQ-036 Scenario: fetch_pc = 0xFFFF_FFFF_FFFF_FFFC -> next request address is 0x0.
REQ-037 Scenario: resetl pulsed low mid-stream with queue full -> outputs zero during reset; first request after release uses startpc.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared widths, PC step and queue entry type for the fetch front end
// Rev    : 1.0
// ============================================================================
package fetch_pkg;
    localparam int XLEN_DEFAULT = 64;
    localparam int INST_W       = 32;
    localparam int PC_STEP      = 4;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [INST_W-1:0]       inst;
    } fetch_entry_t;
endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module : fetch_queue_if
// Brief  : Instruction-memory and decode handshakes of the fetch queue
// Rev    : 1.0
// ============================================================================
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic              imem_req_valid;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_req_ready;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;
    logic              inst_valid;
    logic [INST_W-1:0] inst_data;
    logic [XLEN-1:0]   inst_pc;
    logic              inst_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module : fetch_fifo
// Brief  : Prefetch queue with flush; head is read straight from storage flops
// Rev    : 1.0
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 96
) (
    input  wire logic                   CLK,
    input  wire logic                   resetl,
    input  wire logic                   push_i,
    input  wire logic [W-1:0]           wdata_i,
    input  wire logic                   pop_i,
    input  wire logic                   flush_i,
    output logic                        valid_o,
    output logic [W-1:0]                rdata_o,
    output logic [$clog2(DEPTH):0]      count_o
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [W-1:0]       mem_q [DEPTH];
    logic [c_PTR_W-1:0] rd_ptr_q;
    logic [c_PTR_W-1:0] wr_ptr_q;
    logic [c_CNT_W-1:0] count_q;
    logic               w_pop;
    logic               w_push;

    // A full queue still accepts a push when the head leaves in the same cycle
    assign w_pop  = pop_i && (count_q != '0);
    assign w_push = push_i && ((count_q != c_CNT_W'(DEPTH)) || w_pop);

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
            if (flush_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            end
        end
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : fetch_queue
// Brief  : Credit-limited sequential fetch with redirect flush and discard
// Rev    : 1.0
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  wire logic            CLK,
    input  wire logic            resetl,
    input  wire logic [XLEN-1:0] startpc,
    input  wire logic            redirect,
    input  wire logic [XLEN-1:0] redirect_pc,
    fetch_queue_if.master        bus
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]        fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]        resp_pc_q, resp_pc_d;
    logic [c_CNT_W-1:0]     outstanding_q, outstanding_d;
    logic [c_CNT_W-1:0]     discard_q, discard_d;
    logic [c_CNT_W-1:0]     w_occ;
    logic [c_CNT_W:0]       w_inflight;
    logic [XLEN-1:0]        w_redir_pc;
    logic                   w_accept;
    logic                   w_push;
    logic [XLEN+INST_W-1:0] w_rdata;

    assign w_redir_pc = redirect_pc & ~XLEN'(3);
    assign w_inflight = {1'b0, w_occ} + {1'b0, outstanding_q};

    assign bus.imem_req_valid = resetl && !redirect &&
                                (w_inflight < (c_CNT_W+1)'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc_q;
    assign w_accept           = bus.imem_req_valid && bus.imem_req_ready;
    assign w_push             = bus.imem_resp_valid && !redirect && (discard_q == '0);

    // Responses return in order with no gaps, so the next kept response
    // always belongs to resp_pc_q; no per-request PC storage is needed.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + c_CNT_W'(w_accept) - c_CNT_W'(bus.imem_resp_valid);
        if (redirect) begin
            fetch_pc_d = w_redir_pc;
            resp_pc_d  = w_redir_pc;
            discard_d  = outstanding_q - c_CNT_W'(bus.imem_resp_valid);
        end else begin
            if (w_accept) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            if (w_push)   resp_pc_d  = resp_pc_q + XLEN'(PC_STEP);
            if (bus.imem_resp_valid && (discard_q != '0)) discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            fetch_pc_q    <= startpc;
            resp_pc_q     <= startpc;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (XLEN + INST_W)
    ) u_fifo (
        .CLK     (CLK),
        .resetl  (resetl),
        .push_i  (w_push),
        .wdata_i ({resp_pc_q, bus.imem_resp_data}),
        .pop_i   (bus.inst_ready),
        .flush_i (redirect),
        .valid_o (bus.inst_valid),
        .rdata_o (w_rdata),
        .count_o (w_occ)
    );

    assign bus.inst_pc   = w_rdata[XLEN+INST_W-1:INST_W];
    assign bus.inst_data = w_rdata[INST_W-1:0];
endmodule
`default_nettype wire
